// File: rtl/hood_pkg.sv
// -----------------------------------------------------------------------------
// hood_pkg
// Shared definitions for the range hood session scheduler:
//   - state encoding (OFF / ON / CLEAN), matching the 2-bit `state` output
//   - default values for the scheduler timing parameters
//   - saturation limit of the 16-bit fan working-time accumulator
// No ports (package).
// -----------------------------------------------------------------------------
package hood_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_CLEAN = 2'b10
    } hood_state_t;

    localparam int unsigned DEF_CLEAN_SECS      = 180;
    localparam int unsigned DEF_IDLE_OFF_SECS   = 60;
    localparam int unsigned DEF_WORK_LIMIT_SECS = 36000;

    localparam logic [15:0] WORK_SAT = 16'hFFFF;

endpackage

// File: rtl/tick_countdown.sv
// -----------------------------------------------------------------------------
// tick_countdown
// 8-bit loadable down-counter stepped by a once-per-second tick enable.
// A load always wins over a tick on the same cycle. The counter stops at 0.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   load       in   load `load_value` on the next edge
//   load_value in   8-bit value to load
//   tick_en    in   decrement by one on the next edge (when not loading)
//   count      out  current count (registered)
//   expire     out  tick_en while count == 1, i.e. this tick ends the count
// -----------------------------------------------------------------------------
module tick_countdown (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       tick_en,
    output logic [7:0] count,
    output logic       expire
);

    assign expire = tick_en && (count == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (tick_en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/hood_session_scheduler.sv
// -----------------------------------------------------------------------------
// hood_session_scheduler
// Power and session scheduler for the range hood. Owns the on/off state fed to
// the fan-mode block, powers off after a period of fan inactivity, sequences a
// timed self-clean cycle and accumulates fan working time for a cleaning
// reminder.
//
// Build option:
//   HOOD_AUTO_OFF_EN  defined   -> idle auto-off counter is built and active
//                     undefined -> ON never times out, idle_countdown reads 0
//
// Parameters:
//   CLEAN_SECS       self-clean duration in seconds (1..255)
//   IDLE_OFF_SECS    fan-idle seconds before auto power-off (1..255)
//   WORK_LIMIT_SECS  accumulated fan seconds that raise the reminder (1..65535)
//
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   tick_1hz         in   one-cycle pulse per second
//   power_key        in   debounced power key press pulse
//   clean_key        in   debounced clean key press pulse
//   fan_busy         in   fan block busy flag
//   fan_cd_active    in   fan block countdown in progress
//   is_on            out  machine powered (to fan block is_on)
//   state            out  00 OFF, 01 ON, 10 CLEAN
//   clean_active     out  self-clean actuator enable
//   clean_countdown  out  remaining clean seconds (0 outside CLEAN)
//   idle_countdown   out  remaining seconds to auto-off (0 outside ON)
//   work_seconds     out  accumulated fan seconds, saturating
//   clean_reminder   out  work_seconds >= WORK_LIMIT_SECS, one cycle behind
// -----------------------------------------------------------------------------
module hood_session_scheduler
    import hood_pkg::*;
#(
    parameter int unsigned CLEAN_SECS      = DEF_CLEAN_SECS,
    parameter int unsigned IDLE_OFF_SECS   = DEF_IDLE_OFF_SECS,
    parameter int unsigned WORK_LIMIT_SECS = DEF_WORK_LIMIT_SECS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        power_key,
    input  logic        clean_key,
    input  logic        fan_busy,
    input  logic        fan_cd_active,
    output logic        is_on,
    output logic [1:0]  state,
    output logic        clean_active,
    output logic [7:0]  clean_countdown,
    output logic [7:0]  idle_countdown,
    output logic [15:0] work_seconds,
    output logic        clean_reminder
);

    localparam logic [7:0]  CLEAN_V = 8'(CLEAN_SECS);
    localparam logic [7:0]  IDLE_V  = 8'(IDLE_OFF_SECS);
    localparam logic [15:0] LIMIT_V = 16'(WORK_LIMIT_SECS);

    hood_state_t state_q;
    hood_state_t state_next;

    logic clean_start;
    logic clean_done;
    logic clean_expire;
    logic clean_load;
    logic clean_tick;
    logic [7:0] clean_load_value;
    logic idle_expire;

    // Next-state logic. Key-driven transitions are checked before the
    // tick-driven ones so a key always beats a tick on the same cycle.
    always_comb begin
        state_next  = state_q;
        clean_start = 1'b0;
        clean_done  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (power_key) begin
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                // A running fan countdown must never be cut by the power key.
                if (power_key && !fan_cd_active) begin
                    state_next = ST_OFF;
                end else if (clean_key && !fan_busy) begin
                    state_next  = ST_CLEAN;
                    clean_start = 1'b1;
                end else if (idle_expire) begin
                    state_next = ST_OFF;
                end
            end
            ST_CLEAN: begin
                if (power_key) begin
                    state_next = ST_OFF;
                end else if (clean_expire) begin
                    state_next = ST_ON;
                    clean_done = 1'b1;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    // The counters are loaded with 0 whenever the scheduler is not in their
    // state, so their registered count can drive the outputs directly.
    assign clean_tick       = (state_q == ST_CLEAN) && tick_1hz;
    assign clean_load       = clean_start || (state_next != ST_CLEAN);
    assign clean_load_value = clean_start ? CLEAN_V : 8'd0;

    tick_countdown u_clean_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (clean_load),
        .load_value (clean_load_value),
        .tick_en    (clean_tick),
        .count      (clean_countdown),
        .expire     (clean_expire)
    );

`ifdef HOOD_AUTO_OFF_EN
    logic       idle_reload;
    logic       idle_load;
    logic       idle_tick;
    logic [7:0] idle_load_value;

    // Reload on power-up, on return from CLEAN, and on every cycle the fan
    // is busy while staying ON.
    assign idle_reload = ((state_q == ST_OFF) && power_key)
                      || ((state_q == ST_ON) && (state_next == ST_ON) && fan_busy)
                      || clean_done;
    assign idle_tick       = (state_q == ST_ON) && !fan_busy && tick_1hz;
    assign idle_load       = idle_reload || (state_next != ST_ON);
    assign idle_load_value = idle_reload ? IDLE_V : 8'd0;

    tick_countdown u_idle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (idle_load),
        .load_value (idle_load_value),
        .tick_en    (idle_tick),
        .count      (idle_countdown),
        .expire     (idle_expire)
    );
`else
    assign idle_expire    = 1'b0;
    assign idle_countdown = 8'd0;
`endif

    assign state = state_q;

    // is_on and clean_active are registered from the next state so they
    // change on the same edge as `state`.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            is_on          <= 1'b0;
            clean_active   <= 1'b0;
            work_seconds   <= 16'd0;
            clean_reminder <= 1'b0;
        end else begin
            state_q      <= state_next;
            is_on        <= (state_next != ST_OFF);
            clean_active <= (state_next == ST_CLEAN);
            // A completed clean resets the accumulator and the reminder at
            // once instead of waiting for the lagging compare.
            if (clean_done) begin
                work_seconds   <= 16'd0;
                clean_reminder <= 1'b0;
            end else begin
                if ((state_q == ST_ON) && tick_1hz && fan_busy
                    && (work_seconds != WORK_SAT)) begin
                    work_seconds <= work_seconds + 16'd1;
                end
                clean_reminder <= (work_seconds >= LIMIT_V);
            end
        end
    end

endmodule
